// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI memory wrapper: frame layout,
// command encoding and the controller state encoding.
package spi_pkg;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;

  // Command field, rx_data[9:8].
  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  // Controller states; also exported on the interface for observation.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_WAIT = 2'b01,
    TX      = 2'b10
  } ctrl_state_e;

  // Command field of a frame.
  function automatic cmd_e frame_cmd(input logic [FRAME_W-1:0] frame);
    return cmd_e'(frame[FRAME_W-1:DATA_W]);
  endfunction

  // Payload field of a frame.
  function automatic logic [DATA_W-1:0] frame_payload(input logic [FRAME_W-1:0] frame);
    return frame[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/spi_mem_ctrl_if.sv
// Bus between the SPI slave (master modport) and the memory controller
// (slave modport).
//
// Handshake: rx_valid is a one-cycle strobe; rx_data is a complete frame in
// that cycle. There is no ready: a frame arriving while busy is high is
// dropped and answered with a one-cycle cmd_err pulse. tx_valid is a level
// that stays high with tx_data stable until the next accepted frame.
// state mirrors the controller FSM for observation only.
interface spi_mem_ctrl_if;
  import spi_pkg::*;

  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;
  logic               busy;
  logic               cmd_err;
  ctrl_state_e        state;

  modport master (
    output rx_data, rx_valid,
    input  tx_data, tx_valid, busy, cmd_err, state
  );

  modport slave (
    input  rx_data, rx_valid,
    output tx_data, tx_valid, busy, cmd_err, state
  );

endinterface

// File: rtl/spi_mem_ram.sv
// Single-port memory: synchronous write, registered read (one cycle).
// Contents are not reset; dout holds its last read value while not enabled.
module spi_mem_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_W-1:0]     din_i,
  output logic [DATA_W-1:0]     dout_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_q;

  // One access per cycle: a write, or a read into the output register.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= din_i;
      end else begin
        dout_q <= mem_q[addr_i];
      end
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/spi_mem_ctrl.sv
// Command controller behind the SPI slave. Decodes 10-bit frames, keeps the
// write/read address registers, drives the single-port RAM and returns read
// data to the slave. A read is launched into the RAM in the accepting cycle,
// so the RAM output is ready to capture in the following RD_WAIT cycle.
module spi_mem_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic          clk,
  input  logic          rst,
  spi_mem_ctrl_if.slave ctrl
);

  // Depth must match the address space exactly.
  if (MEM_DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("spi_mem_ctrl: MEM_DEPTH must equal 2**ADDR_WIDTH");
  end

  ctrl_state_e           state_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [DATA_W-1:0]     tx_data_q;
  logic                  tx_valid_q;
  logic                  busy_q;
  logic                  cmd_err_q;

  cmd_e                  cmd;
  logic [DATA_W-1:0]     payload;
  logic [ADDR_WIDTH-1:0] payload_addr;
  logic                  accept;

  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_W-1:0]     ram_dout;

  assign cmd          = frame_cmd(ctrl.rx_data);
  assign payload      = frame_payload(ctrl.rx_data);
  assign payload_addr = payload[ADDR_WIDTH-1:0];

  // Frames are taken in IDLE and TX; RD_WAIT drops them.
  assign accept = ctrl.rx_valid && (state_q != RD_WAIT);

  // RAM port: writes from WR_DATA, reads launched by RD_DATA; nothing under reset.
  always_comb begin
    ram_we   = 1'b0;
    ram_en   = 1'b0;
    ram_addr = rd_addr_q;
    if (accept && !rst) begin
      if (cmd == CMD_WR_DATA) begin
        ram_we   = 1'b1;
        ram_en   = 1'b1;
        ram_addr = wr_addr_q;
      end else if (cmd == CMD_RD_DATA) begin
        ram_en   = 1'b1;
      end
    end
  end

  spi_mem_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (MEM_DEPTH),
    .DATA_W     (DATA_W)
  ) u_ram (
    .clk    (clk),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .din_i  (payload),
    .dout_o (ram_dout)
  );

  // Address registers: loaded by WR_ADDR / RD_ADDR; upper payload bits ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q <= '0;
      rd_addr_q <= '0;
    end else if (accept) begin
      if (cmd == CMD_WR_ADDR) begin
        wr_addr_q <= payload_addr;
      end
      if (cmd == CMD_RD_ADDR) begin
        rd_addr_q <= payload_addr;
      end
    end
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      cmd_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && cmd == CMD_RD_DATA) begin
            state_q <= RD_WAIT;
            busy_q  <= 1'b1;
          end
        end
        RD_WAIT: begin
          tx_data_q  <= ram_dout;
          tx_valid_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= TX;
          if (ctrl.rx_valid) begin
            cmd_err_q <= 1'b1;
          end
        end
        TX: begin
          if (accept) begin
            tx_valid_q <= 1'b0;
            if (cmd == CMD_RD_DATA) begin
              state_q <= RD_WAIT;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl.tx_data  = tx_data_q;
  assign ctrl.tx_valid = tx_valid_q;
  assign ctrl.busy     = busy_q;
  assign ctrl.cmd_err  = cmd_err_q;
  assign ctrl.state    = state_q;

  // RD_WAIT always lasts exactly one cycle.
  a_rd_wait_one: assert property (@(posedge clk) disable iff (rst)
    (state_q == RD_WAIT) |=> (state_q == TX));

  // busy is high exactly in RD_WAIT.
  a_busy_state: assert property (@(posedge clk) disable iff (rst)
    busy_q == (state_q == RD_WAIT));

  // Data is presented only from TX.
  a_tx_valid_state: assert property (@(posedge clk) disable iff (rst)
    tx_valid_q == (state_q == TX));

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: two instances (ADDR_WIDTH 8 and 4) receive the
// same frames; a frame-level reference model predicts every output each cycle.
module tb_spi_mem_ctrl;
  import spi_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_mem_ctrl_if if8 ();
  spi_mem_ctrl_if if4 ();

  spi_mem_ctrl #(.ADDR_WIDTH(8), .MEM_DEPTH(256)) u_dut8 (
    .clk  (clk),
    .rst  (rst),
    .ctrl (if8.slave)
  );

  spi_mem_ctrl #(.ADDR_WIDTH(4), .MEM_DEPTH(16)) u_dut4 (
    .clk  (clk),
    .rst  (rst),
    .ctrl (if4.slave)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per instance k (0: 8-bit addresses, 1: 4-bit addresses).
  logic [7:0] m_mem   [2][256];
  logic [7:0] m_wa    [2];
  logic [7:0] m_ra    [2];
  logic       m_pend  [2];   // a read was accepted on the previous edge
  logic [7:0] m_pdata [2];
  logic       e_tv    [2];
  logic [7:0] e_td    [2];
  logic       e_busy  [2];
  logic       e_err   [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_wa[k] = 8'h00; m_ra[k] = 8'h00; m_pend[k] = 1'b0; m_pdata[k] = 8'h00;
      e_tv[k] = 1'b0; e_td[k] = 8'h00; e_busy[k] = 1'b0; e_err[k] = 1'b0;
    end
  end

  // Outputs expected after one clock edge with the given inputs.
  task automatic model_step(input logic r, input logic v, input logic [9:0] d);
    logic [7:0] mask;
    logic [7:0] p;
    logic [1:0] c;
    logic       acc;
    logic       was_pend;
    for (int k = 0; k < 2; k++) begin
      mask = (k == 0) ? 8'hFF : 8'h0F;
      p = d[7:0];
      c = d[9:8];
      if (r) begin
        m_wa[k] = 8'h00; m_ra[k] = 8'h00; m_pend[k] = 1'b0;
        e_tv[k] = 1'b0; e_td[k] = 8'h00; e_busy[k] = 1'b0; e_err[k] = 1'b0;
      end else begin
        was_pend = m_pend[k];
        acc      = v && !was_pend;
        e_err[k] = v && was_pend;
        if (was_pend) begin
          e_tv[k] = 1'b1;
          e_td[k] = m_pdata[k];
        end else if (acc) begin
          e_tv[k] = 1'b0;
        end
        e_busy[k] = acc && (c == 2'd3);
        m_pend[k] = acc && (c == 2'd3);
        if (acc) begin
          case (c)
            2'd0: m_wa[k] = p & mask;
            2'd1: m_mem[k][m_wa[k]] = p;
            2'd2: m_ra[k] = p & mask;
            default: m_pdata[k] = m_mem[k][m_ra[k]];
          endcase
        end
      end
    end
  endtask

  function automatic logic [1:0] exp_state(input int k);
    if (e_busy[k])    return RD_WAIT;
    else if (e_tv[k]) return TX;
    else              return IDLE;
  endfunction

  task automatic compare_all();
    check_eq("tv8",   if8.tx_valid, e_tv[0]);
    check_eq("td8",   if8.tx_data,  e_td[0]);
    check_eq("busy8", if8.busy,     e_busy[0]);
    check_eq("err8",  if8.cmd_err,  e_err[0]);
    check_eq("st8",   if8.state,    exp_state(0));
    check_eq("tv4",   if4.tx_valid, e_tv[1]);
    check_eq("td4",   if4.tx_data,  e_td[1]);
    check_eq("busy4", if4.busy,     e_busy[1]);
    check_eq("err4",  if4.cmd_err,  e_err[1]);
    check_eq("st4",   if4.state,    exp_state(1));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change just after a rising edge; outputs are sampled 1 time unit
  // after the next rising edge.
  task automatic drive(input logic r, input logic v, input logic [9:0] d);
    rst          = r;
    if8.rx_valid = v;
    if8.rx_data  = d;
    if4.rx_valid = v;
    if4.rx_data  = d;
    @(posedge clk);
    model_step(r, v, d);
    #1;
    compare_all();
  endtask

  task automatic send(input logic [9:0] d);
    drive(1'b0, 1'b1, d);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 10'($urandom_range(0, 1023)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst          = 1'b1;
    if8.rx_valid = 1'b0;
    if8.rx_data  = '0;
    if4.rx_valid = 1'b0;
    if4.rx_data  = '0;

    // Reset values
    drive(1'b1, 1'b0, 10'h000);
    drive(1'b1, 1'b0, 10'h000);
    check_eq("rst_tv",   if8.tx_valid, 1'b0);
    check_eq("rst_td",   if8.tx_data,  8'h00);
    check_eq("rst_busy", if8.busy,     1'b0);
    check_eq("rst_err",  if8.cmd_err,  1'b0);
    drive(1'b0, 1'b0, 10'h000);

    // Fill memory with a known pattern so every read is defined
    for (int i = 0; i < 256; i++) begin
      send({2'b00, 8'(i)});
      send({2'b01, 8'(i) ^ 8'h5A});
    end

    // Write / read back
    send(10'h03C);
    send(10'h1A5);
    send(10'h23C);
    send(10'h300);
    check_eq("rb_busy", if8.busy, 1'b1);
    check_eq("rb_tv0",  if8.tx_valid, 1'b0);
    idle();
    check_eq("rb_tv",  if8.tx_valid, 1'b1);
    check_eq("rb_td8", if8.tx_data,  8'hA5);
    check_eq("rb_td4", if4.tx_data,  8'hA5);

    // Second write/read pair issued while data is presented
    send(10'h03D);
    check_eq("b2b_drop", if8.tx_valid, 1'b0);
    send(10'h15A);
    send(10'h23D);
    send(10'h300);
    check_eq("b2b_tv0", if8.tx_valid, 1'b0);
    idle();
    check_eq("b2b_tv", if8.tx_valid, 1'b1);
    check_eq("b2b_td", if8.tx_data,  8'h5A);

    // Read directly from TX: one cycle of tx_valid low
    send(10'h300);
    check_eq("rr_tv0",  if8.tx_valid, 1'b0);
    check_eq("rr_busy", if8.busy,     1'b1);
    idle();
    check_eq("rr_tv", if8.tx_valid, 1'b1);
    check_eq("rr_td", if8.tx_data,  8'h5A);

    // Frame dropped while busy
    send(10'h300);
    send(10'h1FF);
    check_eq("drop_err", if8.cmd_err,  1'b1);
    check_eq("drop_tv",  if8.tx_valid, 1'b1);
    check_eq("drop_td",  if8.tx_data,  8'h5A);
    idle();
    check_eq("drop_err0", if8.cmd_err, 1'b0);
    send(10'h300);
    idle();
    check_eq("drop_keep", if8.tx_data, 8'h5A);

    // Address wrap on the 4-bit instance
    send(10'h0F3);
    send(10'h177);
    send(10'h203);
    send(10'h300);
    idle();
    check_eq("wrap_td4", if4.tx_data, 8'h77);
    check_eq("wrap_td8", if8.tx_data, 8'h03 ^ 8'h5A);

    // Reset during RD_WAIT
    send(10'h300);
    drive(1'b1, 1'b0, 10'h000);
    check_eq("mr_tv",   if8.tx_valid, 1'b0);
    check_eq("mr_busy", if8.busy,     1'b0);
    drive(1'b0, 1'b0, 10'h000);
    check_eq("mr_tv1", if8.tx_valid, 1'b0);
    send(10'h300);
    idle();
    check_eq("mr_td8", if8.tx_data, 8'h5A);
    check_eq("mr_td4", if4.tx_data, 8'hAA);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) == 0),
            1'($urandom_range(0, 1)),
            10'($urandom_range(0, 1023)));
    end
    for (int n = 0; n < 4; n++) idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
